// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: one-entry stereo holding register, per-frame shadow
// register, and BCLK/LRCK/DATA generation divided down from the system clock.
module i2s_dac_tx #(
  parameter int BCLK_DIV = 2,
  parameter int SLOT_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  output logic                bclk,
  output logic                lrck,
  output logic                dacdat,
  output logic                frame_start,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int K_W   = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * SLOT_W - 1);
  localparam logic [K_W-1:0]   K_SLOT   = K_W'(SLOT_W);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                lrck_q, lrck_d;
  logic                dacdat_q, dacdat_d;
  logic                fs_q, fs_d;
  logic                ur_q, ur_d;
  logic [15:0]         underrun_cnt_q, underrun_cnt_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] shd_l_q, shd_l_d;
  logic [SAMPLE_W-1:0] shd_r_q, shd_r_d;

  logic           xfer;
  logic           div_tc;
  logic [K_W-1:0] k_nx;
  logic           lrck_nx;
  logic [K_W-1:0] j_nx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Slot position j carries sample bit SAMPLE_W-j (MSB at j=1); all other slots pad with 0.
  function automatic logic pick_bit(input logic [SAMPLE_W-1:0] ch, input logic [K_W-1:0] j);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (j == K_W'(SAMPLE_W - i)) b = ch[i];
    end
    return b;
  endfunction

  assign xfer    = sample_valid && !full_q;
  assign div_tc  = (div_q == DIV_LAST);
  assign k_nx    = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
  assign lrck_nx = (k_nx >= K_SLOT);
  assign j_nx    = lrck_nx ? k_nx - K_SLOT : k_nx;

  always_comb begin
    div_d          = div_q;
    bclk_d         = bclk_q;
    k_d            = k_q;
    lrck_d         = lrck_q;
    dacdat_d       = dacdat_q;
    fs_d           = 1'b0;
    ur_d           = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    full_d         = full_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    shd_l_d        = shd_l_q;
    shd_r_d        = shd_r_q;

    if (!en) begin
      div_d    = '0;
      bclk_d   = 1'b0;
      k_d      = K_LAST;
      lrck_d   = 1'b1;
      dacdat_d = 1'b0;
      shd_l_d  = '0;
      shd_r_d  = '0;
    end else if (div_tc) begin
      div_d  = '0;
      bclk_d = !bclk_q;
      if (bclk_q) begin
        k_d      = k_nx;
        lrck_d   = lrck_nx;
        dacdat_d = pick_bit(lrck_nx ? shd_r_q : shd_l_q, j_nx);
        // Frame boundary: j is 0 here so dacdat is padding and the shadow can be swapped now.
        if (k_nx == '0) begin
          fs_d = 1'b1;
          if (full_q) begin
            shd_l_d = hold_l_q;
            shd_r_d = hold_r_q;
            full_d  = 1'b0;
          end else begin
            shd_l_d        = '0;
            shd_r_d        = '0;
            ur_d           = 1'b1;
            underrun_cnt_d = sat_inc(underrun_cnt_q);
          end
        end
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (xfer) begin
      hold_l_d = sample_left;
      hold_r_d = sample_right;
      full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q          <= '0;
      bclk_q         <= 1'b0;
      k_q            <= K_LAST;
      lrck_q         <= 1'b1;
      dacdat_q       <= 1'b0;
      fs_q           <= 1'b0;
      ur_q           <= 1'b0;
      underrun_cnt_q <= '0;
      full_q         <= 1'b0;
      shd_l_q        <= '0;
      shd_r_q        <= '0;
    end else begin
      div_q          <= div_d;
      bclk_q         <= bclk_d;
      k_q            <= k_d;
      lrck_q         <= lrck_d;
      dacdat_q       <= dacdat_d;
      fs_q           <= fs_d;
      ur_q           <= ur_d;
      underrun_cnt_q <= underrun_cnt_d;
      full_q         <= full_d;
      shd_l_q        <= shd_l_d;
      shd_r_q        <= shd_r_d;
    end
  end

  // Holding data is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign sample_ready = !full_q;
  assign bclk         = bclk_q;
  assign lrck         = lrck_q;
  assign dacdat       = dacdat_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: default instance for framing/flow control,
// a fast-divider instance for underrun counter saturation.
module tb_i2s_dac_tx;

  localparam int BCLK_DIV = 2;
  localparam int BIT_CLKS = 2 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_ready, bclk, lrck, dacdat, frame_start, underrun;
  logic [15:0] underrun_cnt;

  logic        f_en = 1'b0;
  logic        f_valid = 1'b0;
  logic [0:0]  f_left = '0;
  logic [0:0]  f_right = '0;
  logic        f_ready, f_bclk, f_lrck, f_dacdat, f_fs, f_ur;
  logic [15:0] f_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2s_dac_tx #(.BCLK_DIV(2), .SLOT_W(32), .SAMPLE_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_left(sample_left), .sample_right(sample_right),
    .bclk(bclk), .lrck(lrck), .dacdat(dacdat),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  i2s_dac_tx #(.BCLK_DIV(1), .SLOT_W(2), .SAMPLE_W(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .en(f_en),
    .sample_valid(f_valid), .sample_ready(f_ready),
    .sample_left(f_left), .sample_right(f_right),
    .bclk(f_bclk), .lrck(f_lrck), .dacdat(f_dacdat),
    .frame_start(f_fs), .underrun(f_ur), .underrun_cnt(f_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b0);
    chk({tag, "_lrck"}, lrck, 1'b1);
    chk({tag, "_dat"}, dacdat, 1'b0);
    chk({tag, "_rdy"}, sample_ready, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ur"}, underrun, 1'b0);
    chk({tag, "_cnt"}, underrun_cnt, 16'h0000);
  endtask

  task automatic wait_fs(input string tag);
    int c;
    c = 0;
    while (!frame_start && c < 400) begin
      tick();
      c++;
    end
    chk(tag, frame_start, 1'b1);
  endtask

  // Samples dacdat once per bit period for one full frame (64 bits).
  task automatic get_frame(output logic [31:0] l, output logic [31:0] r);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++) begin
      w = {w[62:0], dacdat};
      tick(BIT_CLKS);
    end
    l = w[63:32];
    r = w[31:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fl, fr;
    int c, np, early, exp_cnt;
    int t[3];
    logic dat_or;

    #12;
    chk_reset_vals("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Basic frame
    push(16'hA5C3, 16'h8001);
    chk("basic_rdy_lo", sample_ready, 1'b0);
    en = 1'b1;
    tick(3);
    chk("basic_pre_fs", frame_start, 1'b0);
    chk("basic_pre_lrck", lrck, 1'b1);
    tick();
    chk("basic_fs", frame_start, 1'b1);
    chk("basic_lrck", lrck, 1'b0);
    chk("basic_rdy_hi", sample_ready, 1'b1);
    chk("basic_no_ur", underrun, 1'b0);
    get_frame(fl, fr);
    chk("basic_left", fl, 32'h52E1_8000);
    chk("basic_right", fr, 32'h4000_8000);
    chk("basic_ur2", underrun, 1'b1);
    chk("basic_cnt1", underrun_cnt, 16'd1);
    chk("basic_bclk_lo", bclk, 1'b0);
    tick(2);
    chk("basic_bclk_hi", bclk, 1'b1);
    en = 1'b0;
    tick();
    chk("idle_bclk", bclk, 1'b0);
    chk("idle_lrck", lrck, 1'b1);

    // Underrun: three silent frames, then asynchronous reset mid-frame
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    en = 1'b1;
    np = 0;
    dat_or = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      tick();
      if (underrun) begin
        if (np < 3) t[np] = cyc;
        np++;
      end
      dat_or = dat_or | dacdat;
    end
    chk("ur_pulses", np, 3);
    chk("ur_first", t[0], 4);
    chk("ur_gap1", t[1] - t[0], 256);
    chk("ur_gap2", t[2] - t[1], 256);
    chk("ur_cnt", underrun_cnt, 16'd3);
    chk("ur_silent", dat_or, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick(3);
    chk_reset_vals("arst_hold");
    reset_n = 1'b1;
    en = 1'b0;
    tick();

    // Backpressure: P1 then P2 offered back-to-back
    sample_valid = 1'b1;
    sample_left  = 16'h1234;
    sample_right = 16'hFEDC;
    tick();
    chk("bp_rdy_lo", sample_ready, 1'b0);
    sample_left  = 16'h8000;
    sample_right = 16'h0001;
    en = 1'b1;
    c = 0;
    early = 0;
    do begin
      tick();
      c++;
      if (!frame_start && sample_ready) early = 1;
    end while (!frame_start && c < 400);
    chk("bp_fs", frame_start, 1'b1);
    chk("bp_wait", early, 0);
    chk("bp_rdy_hi", sample_ready, 1'b1);
    tick();
    sample_valid = 1'b0;
    chk("bp_p2_taken", sample_ready, 1'b0);
    get_frame(fl, fr);
    chk("bp_p1_left", fl, 32'h091A_0000);
    chk("bp_p1_right", fr, 32'h7F6E_0000);
    chk("bp_no_ur", underrun_cnt, 16'd0);
    get_frame(fl, fr);
    chk("bp_p2_left", fl, 32'h4000_0000);
    chk("bp_p2_right", fr, 32'h0000_8000);
    en = 1'b0;
    tick();

    // Enable drop at k=40 with a pair waiting in the holding register
    push(16'h0000, 16'hFFFF);
    en = 1'b1;
    wait_fs("drop_fs1");
    push(16'h0F0F, 16'hF0F0);
    tick(40 * BIT_CLKS - 1);
    chk("drop_k40_lrck", lrck, 1'b1);
    chk("drop_k40_dat", dacdat, 1'b1);
    en = 1'b0;
    tick();
    chk("drop_bclk", bclk, 1'b0);
    chk("drop_lrck", lrck, 1'b1);
    chk("drop_dat", dacdat, 1'b0);
    chk("drop_full", sample_ready, 1'b0);
    tick(10);
    chk("drop_idle_fs", frame_start, 1'b0);
    en = 1'b1;
    tick(3);
    chk("reen_pre_fs", frame_start, 1'b0);
    tick();
    chk("reen_fs", frame_start, 1'b1);
    chk("reen_no_ur", underrun, 1'b0);
    chk("reen_rdy", sample_ready, 1'b1);
    chk("reen_cnt", underrun_cnt, 16'd1);
    get_frame(fl, fr);
    chk("reen_left", fl, 32'h0787_8000);
    chk("reen_right", fr, 32'h7878_0000);
    en = 1'b0;

    // Saturation on the fast instance, counter preloaded near the top
    force u_fast.underrun_cnt_q = 16'hFFFD;
    tick(2);
    release u_fast.underrun_cnt_q;
    tick();
    chk("sat_preload", f_cnt, 16'hFFFD);
    f_en = 1'b1;
    np = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (f_ur) begin
        np++;
        exp_cnt = (np <= 2) ? 32'hFFFD + np : 32'hFFFF;
        chk("sat_cnt", f_cnt, exp_cnt);
      end
    end
    chk("sat_pulses", np, 8);
    chk("sat_final", f_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
